// File: rtl/uart_rx_deserializer.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_deserializer
// Description : UART receive stage. Synchronises the serial line, times bits
//               from its own counter with a half-bit offset after the start
//               edge, assembles LSB-first bytes and hands them out through a
//               one-entry valid/ready holding register. Pulses frame_err on a
//               low stop bit and overrun when a byte lands on a full holder.
//               Optional feature macro: UART_RX_PARITY_EN (8E1 framing with a
//               parity_err pulse; default build is 8N1 without that port).
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_deserializer #(
  parameter int CLKS_PER_BIT = 868,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
`ifdef UART_RX_PARITY_EN
  output logic       parity_err,
`endif
  output logic       busy
);

  localparam int                 c_cnt_w     = $clog2(CLKS_PER_BIT);
  localparam logic [c_cnt_w-1:0] c_half_load = c_cnt_w'(CLKS_PER_BIT / 2 - 1);
  localparam logic [c_cnt_w-1:0] c_full_load = c_cnt_w'(CLKS_PER_BIT - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_one   = c_cnt_w'(1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4,
    S_BREAK  = 3'd5
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   rx_prev_q, rx_prev_d;
  logic                   start_q, start_d;
  state_t                 state_q, state_d;
  logic [c_cnt_w-1:0]     cnt_q, cnt_d;
  logic [2:0]             bit_idx_q, bit_idx_d;
  logic [7:0]             shreg_q, shreg_d;
  logic [7:0]             data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   frame_err_q, frame_err_d;
  logic                   overrun_q, overrun_d;
  logic                   rx_s;
  logic                   cnt_zero;
  logic                   byte_done;
`ifdef UART_RX_PARITY_EN
  logic                   parity_err_q, parity_err_d;
  logic                   parity_bad_q, parity_bad_d;
`endif

  assign rx_s     = sync_q[SYNC_STAGES-1];
  assign cnt_zero = (cnt_q == '0);

  // Next-state, counter, shift register and holding-register update logic.
  always_comb begin
    sync_d      = {sync_q[SYNC_STAGES-2:0], rx};
    rx_prev_d   = rx_s;
    // Start edge is registered, so IDLE acts on a flop rather than the chain.
    start_d     = rx_prev_q & ~rx_s;
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_idx_d   = bit_idx_q;
    shreg_d     = shreg_q;
    data_d      = data_q;
    valid_d     = valid_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
    byte_done   = 1'b0;
`ifdef UART_RX_PARITY_EN
    parity_err_d = 1'b0;
    parity_bad_d = parity_bad_q;
`endif

    // Free-running countdown toward the next sample point while framing.
    if (state_q != S_IDLE && state_q != S_BREAK && !cnt_zero) begin
      cnt_d = cnt_q - c_cnt_one;
    end

    // A consumed byte empties the holder unless refilled below.
    if (valid_q && rx_ready) begin
      valid_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (start_q) begin
          cnt_d   = c_half_load;
          state_d = S_START;
        end
      end
      S_START: begin
        if (cnt_zero) begin
          if (rx_s) begin
            // Line came back high by mid-start-bit: treat as a glitch.
            state_d = S_IDLE;
          end else begin
            cnt_d     = c_full_load;
            bit_idx_d = 3'd0;
            state_d   = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (cnt_zero) begin
          shreg_d   = {rx_s, shreg_q[7:1]};
          cnt_d     = c_full_load;
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (cnt_zero) begin
          // Even parity: the parity bit equals the XOR of the data bits.
          parity_bad_d = (rx_s != ^shreg_q);
          parity_err_d = (rx_s != ^shreg_q);
          cnt_d        = c_full_load;
          state_d      = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (cnt_zero) begin
          if (rx_s) begin
`ifdef UART_RX_PARITY_EN
            byte_done = ~parity_bad_q;
`else
            byte_done = 1'b1;
`endif
            state_d = S_IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        // A held-low line must go high before another start can be seen.
        if (rx_s) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Deliver the byte if the holder is empty or draining this cycle.
    if (byte_done) begin
      if (!valid_q || rx_ready) begin
        data_d  = shreg_q;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_q      <= '1;
      rx_prev_q   <= 1'b1;
      start_q     <= 1'b0;
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= 3'd0;
      shreg_q     <= 8'h00;
      data_q      <= 8'h00;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      rx_prev_q   <= rx_prev_d;
      start_q     <= start_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shreg_q     <= shreg_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

`ifdef UART_RX_PARITY_EN
  // Parity pulse and per-frame parity verdict registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      parity_err_q <= 1'b0;
      parity_bad_q <= 1'b0;
    end else begin
      parity_err_q <= parity_err_d;
      parity_bad_q <= parity_bad_d;
    end
  end

  assign parity_err = parity_err_q;
`endif

  assign rx_data   = data_q;
  assign rx_valid  = valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign busy      = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_deserializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_deserializer
// Description : Self-checking bench for uart_rx_deserializer. Bytes expected
//               on the output are queued when their frames are driven and
//               compared as the consumer accepts them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_deserializer;

  localparam int CLKS_PER_BIT = 868;
  localparam int SYNC_STAGES  = 2;
`ifdef UART_RX_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif
  localparam int EXP_LAT = SYNC_STAGES + 1 + CLKS_PER_BIT / 2 + 9 * CLKS_PER_BIT + 1
                           + PAR_BITS * CLKS_PER_BIT;

  logic       clock;
  logic       reset;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun;
  logic       busy;
  logic       parity_err;

  int n_total = 0;
  int n_bad   = 0;
  int xfer_cnt = 0;
  int fe_cnt   = 0;
  int ov_cnt   = 0;
  int pe_cnt   = 0;
  logic [7:0] sb[$];

  uart_rx_deserializer #(
    .CLKS_PER_BIT(CLKS_PER_BIT),
    .SYNC_STAGES (SYNC_STAGES)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .rx        (rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .overrun   (overrun),
`ifdef UART_RX_PARITY_EN
    .parity_err(parity_err),
`endif
    .busy      (busy)
  );

`ifndef UART_RX_PARITY_EN
  assign parity_err = 1'b0;
`endif

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic drive_bit(input logic v);
    rx = v;
    idle(CLKS_PER_BIT);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic par_bit);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    if (PAR_BITS == 1) drive_bit(par_bit);
    drive_bit(stop_bit);
  endtask

  // Output monitor: pulse counters and scoreboard comparison on accepts.
  always @(negedge clock) begin
    if (reset) begin
      if (frame_err)  fe_cnt++;
      if (overrun)    ov_cnt++;
      if (parity_err) pe_cnt++;
      if (rx_valid && rx_ready) begin
        xfer_cnt++;
        if (sb.size() == 0) begin
          check("sb_extra", 32'(rx_data), 32'hFFFF_FFFF);
        end else begin
          check("rx_data", 32'(rx_data), 32'(sb.pop_front()));
        end
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    int x0, f0, o0, p0;
    reset    = 1'b0;
    rx       = 1'b1;
    rx_ready = 1'b1;
    idle(5);
    check("rst_data",  32'(rx_data),   32'h0);
    check("rst_valid", 32'(rx_valid),  32'h0);
    check("rst_busy",  32'(busy),      32'h0);
    check("rst_ferr",  32'(frame_err), 32'h0);
    check("rst_ovr",   32'(overrun),   32'h0);
    reset = 1'b1;
    idle(10);

    // 1: clean frame and exact latency.
    sb.push_back(8'hA5);
    lat = 0;
    fork
      send_frame(8'hA5, 1'b1, ^8'hA5);
      begin
        while (!rx_valid && lat < 12000) begin
          @(posedge clock);
          #1;
          lat++;
        end
      end
    join
    idle(20);
    check("latency", 32'(lat), 32'(EXP_LAT));
    check("t1_ferr", 32'(fe_cnt), 32'h0);
    check("t1_ovr",  32'(ov_cnt), 32'h0);
    check("t1_xfer", 32'(xfer_cnt), 32'h1);

    // 2: short low glitch is rejected at mid-start.
    x0 = xfer_cnt;
    rx = 1'b0;
    idle(100);
    check("t2_busy_hi", 32'(busy), 32'h1);
    idle(200);
    rx = 1'b1;
    idle(600);
    check("t2_busy_lo", 32'(busy), 32'h0);
    check("t2_xfer", 32'(xfer_cnt), 32'(x0));
    check("t2_ferr", 32'(fe_cnt), 32'h0);

    // 3: low stop bit, then line held low.
    x0 = xfer_cnt;
    f0 = fe_cnt;
    send_frame(8'h3C, 1'b0, ^8'h3C);
    idle(2000);
    check("t3_ferr", 32'(fe_cnt), 32'(f0 + 1));
    check("t3_busy_break", 32'(busy), 32'h1);
    check("t3_xfer", 32'(xfer_cnt), 32'(x0));
    rx = 1'b1;
    idle(50);
    check("t3_busy_lo", 32'(busy), 32'h0);
    check("t3_ferr_once", 32'(fe_cnt), 32'(f0 + 1));

    // 4: overrun with a stalled consumer, back-to-back frames.
    o0 = ov_cnt;
    rx_ready = 1'b0;
    sb.push_back(8'h11);
    send_frame(8'h11, 1'b1, ^8'h11);
    send_frame(8'h22, 1'b1, ^8'h22);
    idle(20);
    check("t4_ovr", 32'(ov_cnt), 32'(o0 + 1));
    check("t4_valid", 32'(rx_valid), 32'h1);
    check("t4_data_hold", 32'(rx_data), 32'h11);
    rx_ready = 1'b1;
    idle(1);
    check("t4_valid_drop", 32'(rx_valid), 32'h0);

    // 5: reset in the middle of a frame.
    x0 = xfer_cnt;
    fork
      send_frame(8'hFF, 1'b1, ^8'hFF);
      begin
        idle(3000);
        check("t5_busy_pre", 32'(busy), 32'h1);
        reset = 1'b0;
        #1;
        check("t5_rst_valid", 32'(rx_valid), 32'h0);
        check("t5_rst_busy",  32'(busy),     32'h0);
        check("t5_rst_data",  32'(rx_data),  32'h0);
        check("t5_rst_ferr",  32'(frame_err), 32'h0);
        idle(3);
        reset = 1'b1;
      end
    join
    idle(20);
    sb.push_back(8'h5A);
    send_frame(8'h5A, 1'b1, ^8'h5A);
    idle(20);
    check("t5_xfer", 32'(xfer_cnt), 32'(x0 + 1));

`ifdef UART_RX_PARITY_EN
    // 6: parity mismatch discards the byte; correct parity delivers it.
    x0 = xfer_cnt;
    f0 = fe_cnt;
    p0 = pe_cnt;
    send_frame(8'h07, 1'b1, 1'b0);
    idle(20);
    check("t6_perr", 32'(pe_cnt), 32'(p0 + 1));
    check("t6_xfer_bad", 32'(xfer_cnt), 32'(x0));
    check("t6_ferr", 32'(fe_cnt), 32'(f0));
    sb.push_back(8'h07);
    send_frame(8'h07, 1'b1, 1'b1);
    idle(20);
    check("t6_xfer_good", 32'(xfer_cnt), 32'(x0 + 1));
    check("t6_perr_once", 32'(pe_cnt), 32'(p0 + 1));
`else
    p0 = pe_cnt;
    check("no_perr", 32'(p0), 32'h0);
`endif

    check("sb_drained", 32'(sb.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
